clk_rst_gen: RTL and testbench

Clock-domain housekeeping block for the PLL output clock. It synchronises the PLL lock flag and sequences the system reset: reset is held until lock, then for a fixed hold time. It then generates CHANNELS independent, parametrised clock-enable strobes for the slower MIX subsystems (CPU step, UART, display). It also detects loss of lock and re-enters reset, with a glitch filter and a sticky status flag.

---
 rtl/clk_rst_gen.sv | 161 ++++++++++++++++
 tb/tb_clk_rst_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/clk_rst_gen.sv
// Reset sequencer and clock-enable generator for the PLL clock domain: synchronises lock,
// holds reset until lock plus a fixed hold time, and drops back to reset on filtered lock loss.
module clk_rst_gen #(
    parameter int unsigned                    CHANNELS    = 2,
    parameter int unsigned                    DIV_W       = 16,
    parameter logic [CHANNELS*DIV_W-1:0]      DIVS        = {16'd25, 16'd1},
    parameter int unsigned                    HOLD_CYCLES = 1024,
    parameter int unsigned                    FILTER      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                locked,
    input  logic                clr_lost,
    output logic                rst_out,
    output logic                ready,
    output logic [CHANNELS-1:0] ce,
    output logic                lock_lost
);

    localparam int unsigned HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned FILT_W = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER - 1);

    typedef enum logic [1:0] {
        StWaitLock,
        StHold,
        StRun
    } state_e;

    state_e              state_q, state_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [FILT_W-1:0]   filt_cnt_q, filt_cnt_d;
    logic                locked_m, locked_s;
    logic                loss;
    logic                rst_out_d, ready_d, lock_lost_d;
    logic                run_d, run_q;

    // Two-flop synchroniser for the asynchronous lock flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StWaitLock;
            hold_cnt_q <= '0;
            filt_cnt_q <= '0;
            rst_out    <= 1'b1;
            ready      <= 1'b0;
            lock_lost  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            filt_cnt_q <= filt_cnt_d;
            rst_out    <= rst_out_d;
            ready      <= ready_d;
            lock_lost  <= lock_lost_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        filt_cnt_d = filt_cnt_q;
        loss       = 1'b0;
        unique case (state_q)
            StWaitLock: begin
                hold_cnt_d = '0;
                filt_cnt_d = '0;
                if (locked_s) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                filt_cnt_d = '0;
                // A drop during hold restarts sequencing unfiltered and is not reported.
                if (!locked_s) begin
                    state_d    = StWaitLock;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d    = StRun;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            StRun: begin
                hold_cnt_d = '0;
                if (locked_s) begin
                    filt_cnt_d = '0;
                end else if (filt_cnt_q == FILT_LAST) begin
                    loss       = 1'b1;
                    state_d    = StWaitLock;
                    filt_cnt_d = '0;
                end else begin
                    filt_cnt_d = filt_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = StWaitLock;
                hold_cnt_d = '0;
                filt_cnt_d = '0;
            end
        endcase
    end

    always_comb begin
        rst_out_d   = (state_d != StRun);
        ready_d     = (state_d == StRun);
        lock_lost_d = lock_lost;
        if (loss) begin
            lock_lost_d = 1'b1;
        end else if (clr_lost) begin
            lock_lost_d = 1'b0;
        end
    end

    assign run_d = (state_d == StRun);
    assign run_q = (state_q == StRun);

    // Each divider counter tracks the phase of the coming cycle, so the strobe is registered
    // together with it and lands in RUN cycle DIV, DIV*2, ...
    for (genvar i = 0; i < CHANNELS; i++) begin : g_div
        localparam logic [DIV_W-1:0] DIV      = DIVS[i*DIV_W +: DIV_W];
        localparam logic [DIV_W-1:0] DIV_LAST = DIV - 1'b1;

        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic             ce_q, ce_d;

        always_comb begin
            cnt_d = '0;
            ce_d  = 1'b0;
            if (run_d && (DIV != '0)) begin
                if (run_q && (cnt_q != DIV_LAST)) begin
                    cnt_d = cnt_q + 1'b1;
                end
                ce_d = (cnt_d == DIV_LAST);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
                ce_q  <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                ce_q  <= ce_d;
            end
        end

        assign ce[i] = ce_q;
    end

endmodule

// File: tb/tb_clk_rst_gen.sv
// Bench for clk_rst_gen: two instances (divisors {25,1} and {0,3}) checked every cycle against
// a cycle-counting model, plus directed timing checks with hand-computed literals.
module tb_clk_rst_gen;

    localparam int unsigned HOLD = 16;
    localparam int unsigned FILT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       clr_lost = 1'b0;

    logic       a_rst_out, a_ready, a_lock_lost;
    logic [1:0] a_ce;
    logic       b_rst_out, b_ready, b_lock_lost;
    logic [1:0] b_ce;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    clk_rst_gen #(
        .CHANNELS(2), .DIV_W(16), .DIVS({16'd25, 16'd1}), .HOLD_CYCLES(HOLD), .FILTER(FILT)
    ) dut_a (
        .clk(clk), .rst(rst), .locked(locked), .clr_lost(clr_lost),
        .rst_out(a_rst_out), .ready(a_ready), .ce(a_ce), .lock_lost(a_lock_lost)
    );

    clk_rst_gen #(
        .CHANNELS(2), .DIV_W(16), .DIVS({16'd0, 16'd3}), .HOLD_CYCLES(HOLD), .FILTER(FILT)
    ) dut_b (
        .clk(clk), .rst(rst), .locked(locked), .clr_lost(clr_lost),
        .rst_out(b_rst_out), .ready(b_ready), .ce(b_ce), .lock_lost(b_lock_lost)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 = waiting for lock, 1 = holding, 2 = running.
    int  m_mode = 0;
    int  m_hold = 0;
    int  m_low  = 0;
    int  m_run  = 0;
    bit  m_lost = 1'b0;
    bit  m_l1 = 1'b0, m_ls = 1'b0;
    bit  m_valid = 1'b0;

    function automatic bit m_ce(input int div);
        return (m_mode == 2) && (div != 0) && ((m_run % div) == 0);
    endfunction

    always @(posedge clk) begin
        bit ls_old;
        bit loss;
        if (rst) begin
            m_mode = 0; m_hold = 0; m_low = 0; m_run = 0; m_lost = 1'b0;
            m_l1 = 1'b0; m_ls = 1'b0; m_valid = 1'b1;
        end else begin
            ls_old = m_ls;
            loss   = 1'b0;
            case (m_mode)
                0: if (ls_old) begin m_mode = 1; m_hold = 0; end
                1: begin
                    if (!ls_old) m_mode = 0;
                    else begin
                        m_hold++;
                        if (m_hold == HOLD) begin m_mode = 2; m_run = 0; m_low = 0; end
                    end
                end
                default: begin
                    if (ls_old) m_low = 0;
                    else begin
                        m_low++;
                        if (m_low == FILT) begin loss = 1'b1; m_mode = 0; end
                    end
                end
            endcase
            if (m_mode == 2) m_run++;
            if (loss) m_lost = 1'b1;
            else if (clr_lost) m_lost = 1'b0;
            m_ls = m_l1;
            m_l1 = locked;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("a_rst_out", {31'd0, a_rst_out}, {31'd0, m_mode != 2});
            chk("a_ready", {31'd0, a_ready}, {31'd0, m_mode == 2});
            chk("a_lock_lost", {31'd0, a_lock_lost}, {31'd0, m_lost});
            chk("a_ce", {30'd0, a_ce}, {30'd0, m_ce(25), m_ce(1)});
            chk("b_ready", {31'd0, b_ready}, {31'd0, m_mode == 2});
            chk("b_lock_lost", {31'd0, b_lock_lost}, {31'd0, m_lost});
            chk("b_ce", {30'd0, b_ce}, {30'd0, m_ce(0), m_ce(3)});
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_ready(input logic level, input int max, output int n);
        n = 0;
        while (a_ready !== level && n < max) begin
            tick(1);
            n++;
        end
    endtask

    task automatic wait_ce1(input int max, output int n);
        n = 0;
        while (a_ce[1] !== 1'b1 && n < max) begin
            tick(1);
            n++;
        end
    endtask

    int n;

    initial begin
        tick(2);
        chk("reset rst_out", {31'd0, a_rst_out}, 32'd1);
        chk("reset ready", {31'd0, a_ready}, 32'd0);
        chk("reset ce", {30'd0, a_ce}, 32'd0);
        chk("reset lock_lost", {31'd0, a_lock_lost}, 32'd0);

        // Power-up: sync (2) + detect (1) + hold (16).
        rst = 1'b0;
        locked = 1'b1;
        wait_ready(1'b1, 60, n);
        chk("powerup ready delay", n, 32'd19);
        chk("run cycle1 ce0", {31'd0, a_ce[0]}, 32'd1);
        wait_ce1(60, n);
        chk("first ce1 offset", n, 32'd24);
        tick(1);
        wait_ce1(60, n);
        chk("ce1 period", n, 32'd24);

        // Three-cycle glitch is filtered.
        locked = 1'b0;
        tick(3);
        locked = 1'b1;
        tick(10);
        chk("glitch ready", {31'd0, a_ready}, 32'd1);
        chk("glitch lock_lost", {31'd0, a_lock_lost}, 32'd0);

        // Sustained loss: 2 sync edges then 4 filtered samples.
        locked = 1'b0;
        wait_ready(1'b0, 30, n);
        chk("loss delay", n, 32'd6);
        chk("loss ce", {30'd0, a_ce}, 32'd0);
        chk("loss lock_lost", {31'd0, a_lock_lost}, 32'd1);
        tick(3);

        locked = 1'b1;
        wait_ready(1'b1, 60, n);
        chk("relock ready delay", n, 32'd19);
        wait_ce1(60, n);
        chk("relock ce1 phase", n, 32'd24);
        chk("relock lock_lost sticky", {31'd0, a_lock_lost}, 32'd1);

        clr_lost = 1'b1;
        tick(1);
        clr_lost = 1'b0;
        chk("clr_lost", {31'd0, a_lock_lost}, 32'd0);

        // Loss coinciding with clr_lost: set wins.
        locked = 1'b0;
        tick(5);
        chk("pre-loss ready", {31'd0, a_ready}, 32'd1);
        clr_lost = 1'b1;
        tick(1);
        clr_lost = 1'b0;
        chk("loss+clr ready", {31'd0, a_ready}, 32'd0);
        chk("loss+clr lock_lost", {31'd0, a_lock_lost}, 32'd1);
        tick(1);
        clr_lost = 1'b1;
        tick(1);
        clr_lost = 1'b0;
        chk("clr in wait", {31'd0, a_lock_lost}, 32'd0);

        // Drop seen while hold_cnt==10 restarts a full hold.
        locked = 1'b1;
        tick(11);
        locked = 1'b0;
        tick(1);
        locked = 1'b1;
        wait_ready(1'b1, 60, n);
        chk("hold drop ready delay", n, 32'd19);
        chk("hold drop lock_lost", {31'd0, a_lock_lost}, 32'd0);

        // Reset in RUN.
        tick(7);
        rst = 1'b1;
        tick(1);
        chk("rst rst_out", {31'd0, a_rst_out}, 32'd1);
        chk("rst ready", {31'd0, a_ready}, 32'd0);
        chk("rst ce", {30'd0, a_ce}, 32'd0);
        chk("rst b_ce", {30'd0, b_ce}, 32'd0);
        rst = 1'b0;
        wait_ready(1'b1, 60, n);
        chk("rst ready delay", n, 32'd19);
        chk("div3 cycle1", {30'd0, b_ce}, 32'd0);
        tick(2);
        chk("div3 cycle3", {30'd0, b_ce}, 32'd1);
        chk("div1/25 cycle3", {30'd0, a_ce}, 32'd1);
        tick(3);
        chk("div3 cycle6", {30'd0, b_ce}, 32'd1);
        tick(30);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
